alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the 8-bit combinational CDEC ALU. Keeps the existing 5-bit op encoding and {S, Z, Cy} flag semantics for single-cycle operations, generalised to WIDTH bits. Adds iterative unsigned multiply, divide and modulo behind a start/busy/done handshake. Sits between the XBUS/T-register datapath and the flag register; the sequencer stalls on busy.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is 4 to 32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  5  operation code, sampled with start.
- x  in  WIDTH  X operand (XBUS), sampled with start.
- y  in  WIDTH  T operand (Treg), sampled with start.
- cy  in  1  carry in, sampled with start.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; result and flag are valid and updated.
- flag  out  3  {S, Z, Cy}, registered.
- result  out  WIDTH  registered result.

## Operation
- FSM states:
  - IDLE → RUN on start with an iterative op (11100–11111).
  - RUN → IDLE when the iteration count reaches WIDTH.
  - Single-cycle ops never leave IDLE.
- Single-cycle ops. Carry is bit WIDTH of a WIDTH+1-bit sum.
  - 00000: zero.
  - 00001: pass X.
  - 00010: pass T.
  - 01000: X+T.
  - 01001: X+T+1.
  - 01010: X+T+Cy.
  - 01011: X+~T+1.
  - 01100: X+~T.
  - 01101: X+~T+~Cy.
  - 01110: X+1.
  - 01111: X+all-ones.
  - 10000–10100: AND, OR, XOR, ~X, ~T. Cy=0.
  - 11000: {0, X[W-1:1]}, Cy=cy.
  - 11001: {cy, X[W-1:1]}, Cy=cy.
  - 11011: {X[W-2:0], 0}, Cy=X[W-1].
  - 11010: {X[W-2:0], cy}, Cy=X[W-1].
- Iterative ops. All unsigned, WIDTH steps.
  - 11100 MULL: low half of X*T, shift-add. Cy=1 iff the high half is non-zero.
  - 11101 MULH: high half of X*T. Cy=0.
  - 11110 DIV: quotient of X/T, restoring division, one quotient bit per step. Cy=0.
  - 11111 MOD: remainder of X/T. Cy=0.
- Divide by zero (T=0 for DIV/MOD): completes as a single-cycle op.
  - DIV gives all-ones.
  - MOD gives X.
  - Cy=1 in both cases.
- Unassigned codes (00011–00111, 10101–10111): result 0, flag 3'b010. Never X.
- Flags for every op: S=result[WIDTH-1], Z=(result==0). Cy as listed above.
- result/flag change only on the edge that raises done; they hold otherwise.

## Timing
- Reset: IDLE, busy=0, done=0, result=0, flag=3'b000, internal counter and accumulators cleared.
- Single-cycle op: start sampled at edge E. result/flag/done update at E. done is high for cycle E..E+1 only. Back-to-back starts are accepted every cycle.
- Iterative op: start sampled at edge E.
  - busy=1 from E.
  - Steps occur on edges E+1..E+WIDTH.
  - At E+WIDTH: result/flag written, done=1, busy=0.
  - Latency is WIDTH cycles.
- A new start is accepted on the edge that raises done; busy is already 0 then.
- start while busy=1 is ignored: no queueing, operands not captured.
- rst_n low mid-RUN aborts immediately. No done pulse; outputs return to reset values.
- x/y/cy/op may change freely after the sampling edge; operand registers are used internally.

## Structure
- Package alu_pkg holds:
  - localparam op codes (OP_ZERO … OP_MOD);
  - flag bit indices FLAG_S=2, FLAG_Z=1, FLAG_CY=0;
  - state enum {IDLE, RUN}.
- Sub-module alu_muldiv: WIDTH-parametrised iterative multiplier/divider with its own counter and load/step/finish interface.
- Single-cycle logic stays in alu_seq as a combinational function feeding the output registers.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → result 0x00, flag 3'b011, done one cycle after start, busy never high.
- WIDTH=8, MULL 0x12*0x34 → result 0xA8, flag 3'b101, done exactly 8 cycles after start. MULH same operands → 0x03, flag 3'b000.
- WIDTH=8, DIV 200/7 → 0x1C, flag 3'b000. MOD 200/7 → 0x04. DIV 0x55/0 → 0xFF, flag 3'b101, 1-cycle latency.
- Pulse start with ADD at cycles 2 and 5 of a running MULL → both ignored; the MULL result is unchanged and there is a single done.
- Assert rst_n low at cycle 4 of DIV → busy/done/result/flag go to 0 immediately. A following ADD 1+1 → 0x02.
- WIDTH=16:
  - SUB 0x0000-0x0001 (01011) → 0xFFFF, flag 3'b100.
  - MULL 0x0100*0x0100 → 0x0000, flag 3'b011, 16-cycle latency.
  - Unassigned op 00101 → 0, flag 3'b010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered CDEC ALU: op codes, flag bit
// positions and the sequencer state type.
package alu_pkg;

  // Single-cycle op codes (unchanged from the combinational CDEC ALU)
  localparam logic [4:0] OP_ZERO  = 5'b00000;
  localparam logic [4:0] OP_PASSX = 5'b00001;
  localparam logic [4:0] OP_PASST = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADD1  = 5'b01001;
  localparam logic [4:0] OP_ADC   = 5'b01010;
  localparam logic [4:0] OP_SUB   = 5'b01011;
  localparam logic [4:0] OP_SUBN  = 5'b01100;
  localparam logic [4:0] OP_SBC   = 5'b01101;
  localparam logic [4:0] OP_INC   = 5'b01110;
  localparam logic [4:0] OP_DEC   = 5'b01111;
  localparam logic [4:0] OP_AND   = 5'b10000;
  localparam logic [4:0] OP_OR    = 5'b10001;
  localparam logic [4:0] OP_XOR   = 5'b10010;
  localparam logic [4:0] OP_NOTX  = 5'b10011;
  localparam logic [4:0] OP_NOTT  = 5'b10100;
  localparam logic [4:0] OP_SHR   = 5'b11000;
  localparam logic [4:0] OP_RRC   = 5'b11001;
  localparam logic [4:0] OP_RLC   = 5'b11010;
  localparam logic [4:0] OP_SHL   = 5'b11011;

  // Iterative op codes
  localparam logic [4:0] OP_MULL  = 5'b11100;
  localparam logic [4:0] OP_MULH  = 5'b11101;
  localparam logic [4:0] OP_DIV   = 5'b11110;
  localparam logic [4:0] OP_MOD   = 5'b11111;

  // Bit positions inside the {S, Z, Cy} flag word
  localparam int FLAG_S  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_CY = 0;

  typedef enum logic {IDLE, RUN} state_t;

  // The top three op bits all set marks the multiply/divide group
  function automatic logic is_iter(input logic [4:0] op);
    return op[4:2] == 3'b111;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier/divider. One shift-add or one restoring
// division step per cycle; exposes the next-state accumulators so the
// caller can register the final answer on the same edge as the last step.
module alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;      // product high half / partial remainder
  logic [WIDTH-1:0] lo;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] m;       // multiplicand or divisor
  logic             div_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // One step of either algorithm, selected by the captured operation kind
  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, m};
    hi_nxt  = sum[WIDTH:1];
    lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    if (div_q) begin
      // The remainder stays below the divisor, so shifted - m fits WIDTH bits
      hi_nxt = ge ? WIDTH'(shifted - {1'b0, m}) : shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end
  end

  assign finish = step && (count == LAST);

  // Operand capture on load, accumulator update on each step
  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      count <= '0;
      hi    <= '0;
      lo    <= a;
      m     <= b;
      div_q <= is_div;
    end else if (step) begin
      count <= count + 1'b1;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered CDEC ALU: single-cycle ops complete on the sampling edge,
// multiply/divide/modulo run WIDTH cycles in alu_muldiv behind busy/done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cy,
  output logic             busy,
  output logic             done,
  output logic [2:0]       flag,
  output logic [WIDTH-1:0] result
);

  // Carry sits above the result so a WIDTH+1-bit sum maps straight onto it
  typedef struct packed {
    logic             cy;
    logic [WIDTH-1:0] res;
  } sc_t;

  function automatic sc_t alu_single(input logic [4:0] f_op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic c);
    sc_t r;
    r = '0;
    case (f_op)
      OP_PASSX: r.res = a;
      OP_PASST: r.res = b;
      OP_ADD:   r = sc_t'({1'b0, a} + {1'b0, b});
      OP_ADD1:  r = sc_t'({1'b0, a} + {1'b0, b} + 1'b1);
      OP_ADC:   r = sc_t'({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
      OP_SUB:   r = sc_t'({1'b0, a} + {1'b0, ~b} + 1'b1);
      OP_SUBN:  r = sc_t'({1'b0, a} + {1'b0, ~b});
      OP_SBC:   r = sc_t'({1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~c});
      OP_INC:   r = sc_t'({1'b0, a} + 1'b1);
      OP_DEC:   r = sc_t'({1'b0, a} + {1'b0, {WIDTH{1'b1}}});
      OP_AND:   r.res = a & b;
      OP_OR:    r.res = a | b;
      OP_XOR:   r.res = a ^ b;
      OP_NOTX:  r.res = ~a;
      OP_NOTT:  r.res = ~b;
      OP_SHR:   begin r.res = {1'b0, a[WIDTH-1:1]}; r.cy = c;          end
      OP_RRC:   begin r.res = {c, a[WIDTH-1:1]};    r.cy = c;          end
      OP_SHL:   begin r.res = {a[WIDTH-2:0], 1'b0}; r.cy = a[WIDTH-1]; end
      OP_RLC:   begin r.res = {a[WIDTH-2:0], c};    r.cy = a[WIDTH-1]; end
      // Only reached with a zero divisor; non-zero divisors iterate
      OP_DIV:   begin r.res = '1; r.cy = 1'b1; end
      OP_MOD:   begin r.res = a;  r.cy = 1'b1; end
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] mk_flag(input logic [WIDTH-1:0] res, input logic c);
    logic [2:0] f;
    f          = '0;
    f[FLAG_S]  = res[WIDTH-1];
    f[FLAG_Z]  = (res == '0);
    f[FLAG_CY] = c;
    return f;
  endfunction

  state_t           state, state_nxt;
  logic             div_zero;
  logic             load, step, finish;
  logic [1:0]       it_sel;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] it_res;
  logic             it_cy;
  sc_t              sc;

  assign div_zero = (op[4:1] == 4'b1111) && (y == '0);
  assign sc       = alu_single(op, x, y, cy);
  assign busy     = (state == RUN);

  // Next-state logic: launch iterative work from IDLE, return on the last step
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start && is_iter(op) && !div_zero) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Remember which half of the muldiv accumulators is the answer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    it_sel <= 2'b00;
    else if (load) it_sel <= op[1:0];
  end

  // Select the iterative answer from the final step's next values
  always_comb begin
    it_res = lo_nxt;
    it_cy  = 1'b0;
    case (it_sel)
      2'b00:   begin it_res = lo_nxt; it_cy = |hi_nxt; end
      2'b01:   it_res = hi_nxt;
      2'b10:   it_res = lo_nxt;
      default: it_res = hi_nxt;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op[1]),
    .a      (x),
    .b      (y),
    .finish (finish),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Output registers: written only on the edge that raises done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flag   <= 3'b000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start && !load) begin
        result <= sc.res;
        flag   <= mk_flag(sc.res, sc.cy);
        done   <= 1'b1;
      end else if (finish) begin
        result <= it_res;
        flag   <= mk_flag(it_res, it_cy);
        done   <= 1'b1;
      end
    end
  end

endmodule
